fp_panel_io: RTL and testbench

Parametrised front-panel I/O block for FrontPanel designs. It sits between the board's raw push-buttons and LEDs and the host endpoints, and replaces direct wire-to-pin assignment with:
- per-button synchronisation, debounce and sticky press-event capture, which the host reads via Wire Outs and clears via Trigger Ins;
- per-LED enable with a shared PWM brightness control, driven from Wire Ins.

---
 rtl/fp_panel_pkg.sv | 21 ++
 rtl/fp_debounce.sv | 62 ++++++
 rtl/fp_panel_io.sv | 62 ++++++
 tb/tb_fp_panel_io.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_panel_pkg.sv
// Shared constants and helpers for the front-panel I/O block.
// Holds the parameter defaults, the board pin polarities and a clog2 helper.
package fp_panel_pkg;

    localparam int unsigned DEF_N_BTN      = 4;
    localparam int unsigned DEF_N_LED      = 8;
    localparam int unsigned DEF_DEB_CYCLES = 50000;
    localparam int unsigned DEF_PWM_BITS   = 8;

    // Board pins are active-low on both buttons and LEDs.
    localparam logic BTN_ACTIVE_LEVEL = 1'b0;
    localparam logic LED_ON_LEVEL     = 1'b0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/fp_debounce.sv
// One button: 2-flop synchroniser, debounce counter, accepted level and
// sticky press-event flag.
module fp_debounce
    import fp_panel_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic ti_clk,
    input  logic reset,
    input  logic raw_n,
    input  logic clear,
    output logic level,
    output logic evt,
    output logic evt_nxt
);

    localparam int unsigned     CW       = clog2(DEB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_nxt;

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= (raw_n == BTN_ACTIVE_LEVEL);
            sync2 <= sync1;
        end
    end

    // Any cycle where the synchronised input agrees with the level restarts the count.
    always_comb begin
        cnt_nxt   = '0;
        level_nxt = level;
        if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
                level_nxt = sync2;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
        evt_nxt = (level_nxt & ~level) | (evt & ~clear);
    end

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
            evt   <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            level <= level_nxt;
            evt   <= evt_nxt;
        end
    end

endmodule

// File: rtl/fp_panel_io.sv
// Front-panel I/O: debounced buttons with sticky press events for the host,
// and per-LED enables with a shared PWM brightness.
module fp_panel_io
    import fp_panel_pkg::*;
#(
    parameter int unsigned N_BTN      = DEF_N_BTN,
    parameter int unsigned N_LED      = DEF_N_LED,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int unsigned PWM_BITS   = DEF_PWM_BITS
) (
    input  logic                ti_clk,
    input  logic                reset,
    input  logic [N_BTN-1:0]    button,
    output logic [N_LED-1:0]    led,
    input  logic [N_LED-1:0]    led_en,
    input  logic [PWM_BITS-1:0] led_duty,
    input  logic [N_BTN-1:0]    evt_clear,
    output logic [N_BTN-1:0]    btn_level,
    output logic [N_BTN-1:0]    btn_event,
    output logic                evt_pending
);

    localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

    logic [N_BTN-1:0]    evt_nxt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                on_phase;
    logic [N_LED-1:0]    lit;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        fp_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .ti_clk (ti_clk),
            .reset  (reset),
            .raw_n  (button[i]),
            .clear  (evt_clear[i]),
            .level  (btn_level[i]),
            .evt    (btn_event[i]),
            .evt_nxt(evt_nxt[i])
        );
    end

    // Full-scale duty bypasses the compare so there is no dark cycle at pwm_cnt == all-ones.
    always_comb begin
        on_phase = (pwm_cnt < led_duty) | (led_duty == DUTY_FULL);
        lit      = led_en & {N_LED{on_phase}};
    end

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            pwm_cnt     <= '0;
            led         <= {N_LED{~LED_ON_LEVEL}};
            evt_pending <= 1'b0;
        end else begin
            pwm_cnt     <= pwm_cnt + 1'b1;
            led         <= lit ^ {N_LED{~LED_ON_LEVEL}};
            evt_pending <= |evt_nxt;
        end
    end

endmodule

// File: tb/tb_fp_panel_io.sv
// Scoreboard bench for fp_panel_io with a history-window reference model.
module tb_fp_panel_io;

    localparam int unsigned N_BTN = 4;
    localparam int unsigned N_LED = 8;
    localparam int unsigned DEB   = 4;
    localparam int unsigned PWMB  = 4;
    localparam int unsigned PER   = 1 << PWMB;

    logic             clk;
    logic             reset;
    logic [N_BTN-1:0] button;
    logic [N_LED-1:0] led;
    logic [N_LED-1:0] led_en;
    logic [PWMB-1:0]  led_duty;
    logic [N_BTN-1:0] evt_clear;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_event;
    logic             evt_pending;

    fp_panel_io #(
        .N_BTN(N_BTN), .N_LED(N_LED), .DEB_CYCLES(DEB), .PWM_BITS(PWMB)
    ) dut (
        .ti_clk(clk), .reset(reset), .button(button), .led(led),
        .led_en(led_en), .led_duty(led_duty), .evt_clear(evt_clear),
        .btn_level(btn_level), .btn_event(btn_event), .evt_pending(evt_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_LED-1:0] led;
        logic [N_BTN-1:0] lvl;
        logic [N_BTN-1:0] evt;
        logic             pend;
    } snap_t;

    snap_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, want);
        end
    endtask

    // Reference model: level flips once the synchronised input has disagreed
    // with it for DEB consecutive edges since the last flip; s before edge k
    // is the raw pressed value sampled at edge k-2.
    logic [N_BTN-1:0] raw_hist[$];
    int unsigned      edge_k = 0;
    int unsigned      last_flip[N_BTN];
    logic [N_BTN-1:0] m_lvl = '0;
    logic [N_BTN-1:0] m_evt = '0;

    function automatic logic s_before(input int unsigned k, input int b);
        if (k < 3) return 1'b0;
        return raw_hist[k-2][b];
    endfunction

    always @(posedge clk) begin
        snap_t       s;
        int unsigned cnt;
        logic        flip;
        logic        rise;
        logic        phase;
        if (reset) begin
            edge_k = 0;
            raw_hist.delete();
            raw_hist.push_back('0);
            for (int b = 0; b < N_BTN; b++) last_flip[b] = 0;
            m_lvl = '0;
            m_evt = '0;
            s.led = '1; s.lvl = '0; s.evt = '0; s.pend = 1'b0;
        end else begin
            edge_k++;
            raw_hist.push_back(~button);
            for (int b = 0; b < N_BTN; b++) begin
                flip = (edge_k - last_flip[b] >= DEB);
                if (flip)
                    for (int unsigned j = edge_k - DEB + 1; j <= edge_k; j++)
                        if (s_before(j, b) == m_lvl[b]) flip = 1'b0;
                rise = 1'b0;
                if (flip) begin
                    m_lvl[b]     = ~m_lvl[b];
                    last_flip[b] = edge_k;
                    rise         = m_lvl[b];
                end
                m_evt[b] = rise | (m_evt[b] & ~evt_clear[b]);
            end
            cnt   = (edge_k - 1) % PER;
            phase = (cnt < int'(led_duty)) || (int'(led_duty) == PER - 1);
            for (int i = 0; i < N_LED; i++) s.led[i] = ~(led_en[i] & phase);
            s.lvl  = m_lvl;
            s.evt  = m_evt;
            s.pend = |m_evt;
        end
        exp_q.push_back(s);
    end

    always @(negedge clk) begin
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("led", 32'(led), 32'(e.led));
            chk("btn_level", 32'(btn_level), 32'(e.lvl));
            chk("btn_event", 32'(btn_event), 32'(e.evt));
            chk("evt_pending", 32'(evt_pending), 32'(e.pend));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_reset_now(input string tag);
        chk({tag, "_led"}, 32'(led), 32'hFF);
        chk({tag, "_lvl"}, 32'(btn_level), 32'h0);
        chk({tag, "_evt"}, 32'(btn_event), 32'h0);
        chk({tag, "_pend"}, 32'(evt_pending), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hold[N_BTN];
        int cnt_lit;
        logic seen;
        reset = 1'b1; button = '1; led_en = '0; led_duty = '0; evt_clear = '0;
        cyc(3);
        reset = 1'b0;
        cyc(2);

        // clean press / release on button 0
        led_en = 8'hA5; led_duty = 4'd9;
        button[0] = 1'b0;
        cyc(5);
        chk("press_before", 32'(btn_level[0]), 32'h0);
        cyc(1);
        chk("press_at6", 32'(btn_level[0]), 32'h1);
        chk("press_evt6", 32'(btn_event[0]), 32'h1);
        cyc(10);
        button[0] = 1'b1;
        cyc(6);
        chk("release_at6", 32'(btn_level[0]), 32'h0);
        chk("release_evt_kept", 32'(btn_event[0]), 32'h1);
        cyc(4);

        // bounce on button 1
        button[1] = 1'b0; cyc(3);
        button[1] = 1'b1; cyc(1);
        button[1] = 1'b0; cyc(5);
        chk("bounce_early", 32'(btn_level[1]), 32'h0);
        cyc(1);
        chk("bounce_at6", 32'(btn_level[1]), 32'h1);
        cyc(10);
        button[1] = 1'b1; cyc(10);

        // clear collides with acceptance: set wins
        evt_clear = 4'b0011; cyc(1);
        evt_clear = '0; cyc(1);
        chk("cleared", 32'(btn_event), 32'h0);
        button[0] = 1'b0;
        cyc(5);
        evt_clear[0] = 1'b1; cyc(1);
        evt_clear[0] = 1'b0;
        chk("set_wins", 32'(btn_event[0]), 32'h1);
        cyc(3);
        evt_clear[0] = 1'b1; cyc(1);
        evt_clear[0] = 1'b0;
        chk("clear_alone", 32'(btn_event[0]), 32'h0);
        chk("clear_pend", 32'(evt_pending), 32'h0);
        button[0] = 1'b1; cyc(8);

        // PWM sweep on LED 0
        led_en = 8'h01;
        led_duty = 4'd0; cyc(2 * PER);
        led_duty = 4'd5; cyc(2);
        cnt_lit = 0;
        for (int i = 0; i < int'(PER); i++) begin
            if (led[0] == 1'b0) cnt_lit++;
            cyc(1);
        end
        chk("duty5_count", 32'(cnt_lit), 32'd5);
        led_duty = 4'hF; cyc(2);
        cnt_lit = 0;
        for (int i = 0; i < int'(PER); i++) begin
            if (led[0] == 1'b0) cnt_lit++;
            cyc(1);
        end
        chk("duty15_count", 32'(cnt_lit), 32'(PER));

        // enable drop mid-period
        led_duty = 4'd8; cyc(2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (led[0] == 1'b0) seen = 1'b1;
            else cyc(1);
        end
        chk("en_lit_seen", 32'(seen), 32'h1);
        cyc(1);
        led_en = 8'h00; cyc(1);
        chk("en_off_next", 32'(led[0]), 32'h1);
        cyc(4);

        // randomized traffic
        for (int b = 0; b < N_BTN; b++) hold[b] = 0;
        for (int t = 0; t < 600; t++) begin
            for (int b = 0; b < N_BTN; b++) begin
                if (hold[b] == 0) begin
                    button[b] = $urandom_range(0, 1) == 1;
                    hold[b]   = $urandom_range(1, 10);
                end else hold[b]--;
            end
            evt_clear = '0;
            for (int b = 0; b < N_BTN; b++) evt_clear[b] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) led_duty = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) led_en = 8'($urandom);
            cyc(1);
        end
        evt_clear = '0;

        // button held across a mid-run reset
        button = 4'b1011; led_en = 8'h00; cyc(20);
        reset = 1'b1; #1;
        check_reset_now("rst_async");
        cyc(3);
        reset = 1'b0; cyc(1);
        check_reset_now("rst_after");
        cyc(4);
        chk("rehold_before", 32'(btn_level[2]), 32'h0);
        cyc(1);
        chk("rehold_at6", 32'(btn_level[2]), 32'h1);
        chk("rehold_evt", 32'(btn_event[2]), 32'h1);
        cyc(10);
        button = '1; cyc(10);

        cyc(2);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
